// File: rtl/mux2a1_sync.sv
// mux2a1_sync: parameterised 2-to-1 data selector.
//
// The combinational output Y follows A/B/Sel at all times, including during
// reset. A registered copy y_q, with its out_valid flag, captures the
// selected word on each rising edge where in_valid is high. A saturating
// counter records how many times Sel changes, for debug.
//
// Optional feature: define MUX2A1_SYNC_PARITY_EN to add y_par, the XOR-reduce
// of y_q. It is registered alongside y_q. The default build omits it.
//
// Parameters:
//   WIDTH  data width of A, B, Y and y_q
//   CNT_W  width of the Sel-toggle counter
//
// Ports:
//   clk          system clock; all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   A, B         data inputs, selected by Sel=0 and Sel=1 respectively
//   Sel          select line
//   in_valid     qualifies A/B/Sel for the registered path
//   clr_cnt      synchronous clear of sel_toggles
//   Y            combinational mux output
//   y_q          registered mux output
//   out_valid    y_q was captured at the last edge
//   y_par        parity of y_q (MUX2A1_SYNC_PARITY_EN only)
//   sel_toggles  saturating count of Sel transitions
module mux2a1_sync #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sel,
  input  logic             in_valid,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid,
`ifdef MUX2A1_SYNC_PARITY_EN
  output logic             y_par,
`endif
  output logic [CNT_W-1:0] sel_toggles
);

  logic             sel_prev_q;
  logic [CNT_W-1:0] cnt_d;

  // An X/Z select falls through to the default branch, so Y goes fully X
  // rather than merging the bits that A and B happen to share.
  always_comb begin
    Y = 'x;
    case (Sel)
      1'b0:    Y = A;
      1'b1:    Y = B;
      default: Y = 'x;
    endcase
  end

  // A clear beats an increment in the same cycle. The counter stops at
  // all-ones instead of wrapping.
  always_comb begin
    cnt_d = sel_toggles;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if ((Sel != sel_prev_q) && (sel_toggles != {CNT_W{1'b1}})) begin
      cnt_d = sel_toggles + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q         <= '0;
      out_valid   <= 1'b0;
      sel_toggles <= '0;
      sel_prev_q  <= 1'b0;
    end else begin
      if (in_valid) begin
        y_q <= Y;
      end
      out_valid   <= in_valid;
      sel_toggles <= cnt_d;
      // Sampled every cycle, whatever in_valid says.
      sel_prev_q  <= Sel;
    end
  end

`ifdef MUX2A1_SYNC_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_par <= 1'b0;
    end else if (in_valid) begin
      y_par <= ^Y;
    end
  end
`endif

endmodule

// File: tb/tb_mux2a1_sync.sv
// Self-checking bench for mux2a1_sync (WIDTH=4, CNT_W=2).
// A behavioural model of the registered path, written from the selector
// rules, is updated at each edge and compared against the DUT one time step
// later. Directed sequences come first, then randomized traffic.
module tb_mux2a1_sync;

  localparam int unsigned W    = 4;
  localparam int unsigned CW   = 2;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  A, B;
  logic          Sel, in_valid, clr_cnt;
  logic [W-1:0]  Y, y_q;
  logic          out_valid;
  logic [CW-1:0] sel_toggles;
`ifdef MUX2A1_SYNC_PARITY_EN
  logic          y_par;
`endif

  always #5 clk = ~clk;

  mux2a1_sync #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .A           (A),
    .B           (B),
    .Sel         (Sel),
    .in_valid    (in_valid),
    .clr_cnt     (clr_cnt),
    .Y           (Y),
    .y_q         (y_q),
    .out_valid   (out_valid),
`ifdef MUX2A1_SYNC_PARITY_EN
    .y_par       (y_par),
`endif
    .sel_toggles (sel_toggles)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state.
  logic [W-1:0] m_y;
  logic         m_v;
  int           m_cnt;
  logic         m_prev;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic comb_check();
    logic [W-1:0] exp;
    #1;
    exp = (Sel == 1'b0) ? A : B;
    check_eq("y_comb", Y, exp);
  endtask

  // One clock: update the model from the inputs seen at the edge, then compare.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_y = '0; m_v = 1'b0; m_cnt = 0; m_prev = 1'b0;
    end else begin
      if (in_valid) begin
        m_y = Sel ? B : A;
        m_v = 1'b1;
      end else begin
        m_v = 1'b0;
      end
      if (clr_cnt) m_cnt = 0;
      else if (Sel != m_prev) m_cnt = (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
      m_prev = Sel;
    end
    #1;
    check_eq("y_q", y_q, m_y);
    check_eq("out_valid", out_valid, m_v);
    check_eq("sel_toggles", sel_toggles, m_cnt);
`ifdef MUX2A1_SYNC_PARITY_EN
    check_eq("y_par", y_par, ^m_y);
`endif
  endtask

  initial begin
    int sat_exp [5] = '{1, 2, 3, 3, 3};
    logic [31:0] r;

    rst_n = 1'b0; A = 4'h5; B = 4'hA; Sel = 1'b1; in_valid = 1'b1; clr_cnt = 1'b1;
    m_y = '0; m_v = 1'b0; m_cnt = 0; m_prev = 1'b0;
    comb_check();               // Y is live during reset
    tick();
    tick();
    clr_cnt = 1'b0;
    rst_n   = 1'b1;

    // Combinational sweep over {Sel,B,A} using 1-bit values.
    for (int i = 0; i < 8; i++) begin
      A   = i[0] ? 4'h1 : 4'h0;
      B   = i[1] ? 4'h1 : 4'h0;
      Sel = i[2];
      comb_check();
      tick();
    end

    // Registered latency.
    A = 4'h1; B = 4'h0; Sel = 1'b1; in_valid = 1'b1;
    tick();
    check_eq("lat_sel1", y_q, 32'h0);
    Sel = 1'b0;
    tick();
    check_eq("lat_sel0", y_q, 32'h1);

    // Hold with in_valid low while the inputs keep changing.
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      r = $urandom;
      A = r[3:0]; B = r[7:4]; Sel = r[8];
      comb_check();
      tick();
      check_eq("hold_y_q", y_q, 32'h1);
    end

    // Reset mid-operation.
    in_valid = 1'b1; A = 4'h1; Sel = 1'b0;
    tick();
    rst_n = 1'b0; A = 4'h6; B = 4'h9; Sel = 1'b1;
    comb_check();
    tick();
    check_eq("rst_y_q", y_q, 32'h0);
    check_eq("rst_cnt", sel_toggles, 32'h0);
    comb_check();
    rst_n = 1'b1; Sel = 1'b0; in_valid = 1'b0;

    // Saturation, starting with the counter at 0 and sel_prev at 0.
    for (int k = 0; k < 5; k++) begin
      Sel = (k % 2 == 0);
      tick();
      check_eq("sat_seq", sel_toggles, sat_exp[k]);
    end
    clr_cnt = 1'b1; Sel = 1'b0;   // clear wins over the toggle
    tick();
    check_eq("clr_toggle", sel_toggles, 32'h0);
    clr_cnt = 1'b0;

`ifdef MUX2A1_SYNC_PARITY_EN
    A = 4'b1011; Sel = 1'b0; in_valid = 1'b1;
    tick();
    check_eq("par_1011", y_par, 32'h1);
    A = 4'b1001;
    tick();
    check_eq("par_1001", y_par, 32'h0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      A        = r[3:0];
      B        = r[7:4];
      Sel      = r[8];
      in_valid = r[9];
      clr_cnt  = (r[12:10] == 3'd0);
      rst_n    = (r[17:13] != 5'd0);
      comb_check();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
